// File: rtl/gray_tint_pkg.sv
// ---------------------------------------------------------------------------
// gray_tint_pkg
// Shared constants and helpers for the gray-to-RGB tint pipeline.
//   SEPIA_R/G/B : default per-channel tint weights, unsigned Q2.6
//   ROUND_HALF  : half an LSB of the Q2.6 result, added before truncation
//   FRAC_BITS   : fractional bits of the weights
//   PIX_W       : pixel channel width
//   PROD_W      : width of gray * weight product
//   SUM_W       : product plus rounding headroom
// ---------------------------------------------------------------------------
package gray_tint_pkg;

    localparam int PIX_W     = 4;
    localparam int FRAC_BITS = 6;
    localparam int PROD_W    = 12;
    localparam int SUM_W     = 13;

    localparam logic [7:0]        SEPIA_R    = 8'd72;   // 1.125
    localparam logic [7:0]        SEPIA_G    = 8'd64;   // 1.0
    localparam logic [7:0]        SEPIA_B    = 8'd48;   // 0.75
    localparam logic [PROD_W-1:0] ROUND_HALF = 12'd32;

    localparam logic [SUM_W-1:0]  PIX_MAX_WIDE = 13'd15;
    localparam logic [PIX_W-1:0]  PIX_MAX      = 4'd15;

    // Round a Q*.6 product to an integer pixel, widened so +32 cannot wrap.
    function automatic logic [SUM_W-1:0] roundQ6(input logic [PROD_W-1:0] prod);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, prod} + {1'b0, ROUND_HALF};
        return sum >> FRAC_BITS;
    endfunction

    // Clamp a rounded value into the pixel range.
    function automatic logic [PIX_W-1:0] sat15(input logic [SUM_W-1:0] value);
        logic [PIX_W-1:0] pix;
        if (value > PIX_MAX_WIDE) begin
            pix = PIX_MAX;
        end else begin
            pix = value[PIX_W-1:0];
        end
        return pix;
    endfunction

endpackage

// File: rtl/gray_tint_pipe_tint_channel.sv
// ---------------------------------------------------------------------------
// tint_channel
// Combinational arithmetic for one colour channel. The multiply and the
// round/saturate halves are independent so the top can register the product
// between them.
//   gray    in  4   gray sample to scale
//   prod    out 12  gray * WEIGHT
//   prodIn  in  12  registered product to round and clamp
//   pix     out 4   rounded, saturated channel value
//   clamp   out 1   rounded value exceeded 15 and was clamped
// ---------------------------------------------------------------------------
module tint_channel
    import gray_tint_pkg::*;
#(
    parameter logic [7:0] WEIGHT = SEPIA_R
) (
    input  logic [PIX_W-1:0]  gray,
    output logic [PROD_W-1:0] prod,
    input  logic [PROD_W-1:0] prodIn,
    output logic [PIX_W-1:0]  pix,
    output logic              clamp
);

    logic [SUM_W-1:0] rounded_s;

    // Multiply, then round and saturate the registered product.
    always_comb begin
        prod      = {8'd0, gray} * {4'd0, WEIGHT};
        rounded_s = roundQ6(prodIn);
        clamp     = (rounded_s > PIX_MAX_WIDE);
        pix       = sat15(rounded_s);
    end

endmodule

// File: rtl/gray_tint_pipe.sv
// ---------------------------------------------------------------------------
// gray_tint_pipe
// Two-stage valid/ready pipeline converting 4-bit gray to tinted 4-bit RGB.
// Stage 1 registers the three products, stage 2 rounds/saturates into the
// output registers. A bypass sample copies gray to every channel.
//   clk, rst_n         clock, asynchronous active-low reset
//   s_valid/s_ready    input handshake (s_ready = ~m_valid | m_ready)
//   s_gray, s_bypass   input sample and its bypass qualifier
//   m_valid/m_ready    output handshake
//   m_r, m_g, m_b      output channels
//   m_last             output pixel is index FRAME_PIXELS-1 of its frame
//   sat_flag           (GRAY_TINT_SAT_FLAG_EN only) sticky per-frame clamp flag
// Optional feature macro: GRAY_TINT_SAT_FLAG_EN
// ---------------------------------------------------------------------------
module gray_tint_pipe
    import gray_tint_pkg::*;
#(
    parameter logic [7:0] R_WEIGHT     = SEPIA_R,
    parameter logic [7:0] G_WEIGHT     = SEPIA_G,
    parameter logic [7:0] B_WEIGHT     = SEPIA_B,
    parameter int         FRAME_PIXELS = 76800,
    parameter int         CNT_W        = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_gray,
    input  logic             s_bypass,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_r,
    output logic [PIX_W-1:0] m_g,
    output logic [PIX_W-1:0] m_b,
    output logic             m_last
`ifdef GRAY_TINT_SAT_FLAG_EN
    ,
    output logic             sat_flag
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic              adv_s;
    logic              outXfer_s;
    logic [CNT_W-1:0]  nextIdx_s;

    logic              v1_r;
    logic              byp1_r;
    logic [PIX_W-1:0]  gray1_r;
    logic [PROD_W-1:0] prodR_r, prodG_r, prodB_r;
    logic [PROD_W-1:0] prodR_s, prodG_s, prodB_s;
    logic [PIX_W-1:0]  pixR_s, pixG_s, pixB_s;
    logic              clampR_s, clampG_s, clampB_s;
    logic [CNT_W-1:0]  pixCnt_r;

    tint_channel #(.WEIGHT(R_WEIGHT)) u_red (
        .gray(s_gray), .prod(prodR_s), .prodIn(prodR_r), .pix(pixR_s), .clamp(clampR_s)
    );
    tint_channel #(.WEIGHT(G_WEIGHT)) u_green (
        .gray(s_gray), .prod(prodG_s), .prodIn(prodG_r), .pix(pixG_s), .clamp(clampG_s)
    );
    tint_channel #(.WEIGHT(B_WEIGHT)) u_blue (
        .gray(s_gray), .prod(prodB_s), .prodIn(prodB_r), .pix(pixB_s), .clamp(clampB_s)
    );

    // Advance enable and the frame index the next stage-2 pixel will carry.
    // If the current output leaves this cycle, the incoming pixel takes the
    // following index; otherwise it takes the current counter value.
    always_comb begin
        adv_s     = ~m_valid | m_ready;
        outXfer_s = m_valid & m_ready;
        nextIdx_s = pixCnt_r;
        if (outXfer_s) begin
            if (pixCnt_r == LAST_IDX) begin
                nextIdx_s = CNT_ZERO;
            end else begin
                nextIdx_s = pixCnt_r + CNT_ONE;
            end
        end else begin
            nextIdx_s = pixCnt_r;
        end
    end

    assign s_ready = adv_s;

    // Stage 1: capture products and bypass context on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r    <= 1'b0;
            byp1_r  <= 1'b0;
            gray1_r <= 4'd0;
            prodR_r <= 12'd0;
            prodG_r <= 12'd0;
            prodB_r <= 12'd0;
        end else if (adv_s) begin
            v1_r <= s_valid;
            if (s_valid) begin
                byp1_r  <= s_bypass;
                gray1_r <= s_gray;
                prodR_r <= prodR_s;
                prodG_r <= prodG_s;
                prodB_r <= prodB_s;
            end
        end
    end

    // Stage 2: output registers, loaded whenever the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_r     <= 4'd0;
            m_g     <= 4'd0;
            m_b     <= 4'd0;
        end else if (adv_s) begin
            m_valid <= v1_r;
            m_last  <= v1_r & (nextIdx_s == LAST_IDX);
            if (byp1_r) begin
                m_r <= gray1_r;
                m_g <= gray1_r;
                m_b <= gray1_r;
            end else begin
                m_r <= pixR_s;
                m_g <= pixG_s;
                m_b <= pixB_s;
            end
        end
    end

    // Output-transfer counter, wrapping at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixCnt_r <= CNT_ZERO;
        end else if (outXfer_s) begin
            pixCnt_r <= nextIdx_s;
        end
    end

`ifdef GRAY_TINT_SAT_FLAG_EN
    // Sticky clamp flag; a clamp on the load that coincides with the frame
    // boundary transfer keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (adv_s & v1_r & ~byp1_r & (clampR_s | clampG_s | clampB_s)) begin
            sat_flag <= 1'b1;
        end else if (outXfer_s & m_last) begin
            sat_flag <= 1'b0;
        end else begin
            sat_flag <= sat_flag;
        end
    end
`else
    logic unusedClamp_s;
    assign unusedClamp_s = clampR_s ^ clampG_s ^ clampB_s;
`endif

endmodule

// File: tb/tb_gray_tint_pipe.sv
module tb_gray_tint_pipe;

    localparam int FP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_gray;
    logic       s_bypass;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] m_r, m_g, m_b;
    logic       m_last;
`ifdef GRAY_TINT_SAT_FLAG_EN
    logic       sat_flag;
`endif

    gray_tint_pipe #(.FRAME_PIXELS(FP), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_gray(s_gray), .s_bypass(s_bypass),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_r(m_r), .m_g(m_g), .m_b(m_b), .m_last(m_last)
`ifdef GRAY_TINT_SAT_FLAG_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int r; int g; int b; bit last; bit sat;
    } pix_t;

    pix_t q[$];
    int   total = 0;
    int   bad = 0;
    int   modelIdx = 0;
    bit   satRun = 1'b0;
    bit   prevStall = 1'b0;
    int   heldR, heldG, heldB, heldL;
    int   outCount = 0;
    int   lastPos[$];
    bit   accepted;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference channel value: round-half-up of gray*w/64, clamped to 15.
    function automatic int tint(input int g, input int w);
        int v;
        v = (g * w + 32) / 64;
        return (v > 15) ? 15 : v;
    endfunction

    function automatic bit clamps(input int g, input int w);
        return ((g * w + 32) / 64) > 15;
    endfunction

    task automatic pushModel(input int g, input bit byp);
        pix_t e;
        if (byp) begin
            e.r = g; e.g = g; e.b = g;
        end else begin
            e.r = tint(g, 72); e.g = tint(g, 64); e.b = tint(g, 48);
        end
        if (modelIdx % FP == 0) satRun = 1'b0;
        if (!byp && (clamps(g, 72) || clamps(g, 64) || clamps(g, 48))) satRun = 1'b1;
        e.sat  = satRun;
        e.last = (modelIdx % FP) == FP - 1;
        modelIdx++;
        q.push_back(e);
    endtask

    task automatic checkCycle();
        pix_t e;
        chk("s_ready", int'(s_ready), int'(!m_valid || m_ready));
        if (prevStall) begin
            chk("stall_valid", int'(m_valid), 1);
            chk("stall_r", int'(m_r), heldR);
            chk("stall_g", int'(m_g), heldG);
            chk("stall_b", int'(m_b), heldB);
            chk("stall_last", int'(m_last), heldL);
        end
`ifdef GRAY_TINT_SAT_FLAG_EN
        if (m_valid && q.size() > 0) chk("sat_flag", int'(sat_flag), int'(q[0].sat));
`endif
        if (m_valid && m_ready) begin
            outCount++;
            if (m_last) lastPos.push_back(outCount);
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_r", int'(m_r), e.r);
                chk("out_g", int'(m_g), e.g);
                chk("out_b", int'(m_b), e.b);
                chk("out_last", int'(m_last), int'(e.last));
            end
        end
        accepted = s_valid && s_ready;
        if (accepted) pushModel(int'(s_gray), s_bypass);
        prevStall = m_valid && !m_ready;
        heldR = m_r; heldG = m_g; heldB = m_b; heldL = m_last;
    endtask

    // Called at a falling edge: drive inputs, check, advance one clock.
    task automatic step(input logic v, input logic [3:0] g, input logic b, input logic rdy);
        s_valid = v; s_gray = g; s_bypass = b; m_ready = rdy;
        #1;
        checkCycle();
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && q.size() > 0; i++) step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("drain_empty", q.size(), 0);
    endtask

    // Reset applied mid-cycle; model state is discarded with the DUT's.
    task automatic resetDut();
        #2;
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_last", int'(m_last), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        q.delete();
        lastPos.delete();
        modelIdx = 0; satRun = 1'b0; prevStall = 1'b0; outCount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int g;
        rst_n = 1'b0; s_valid = 1'b0; s_gray = 4'd0; s_bypass = 1'b0; m_ready = 1'b0;
        #12;
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_m_r", int'(m_r), 0);
        chk("reset_m_g", int'(m_g), 0);
        chk("reset_m_b", int'(m_b), 0);
        chk("reset_m_last", int'(m_last), 0);
        chk("reset_s_ready", int'(s_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // gray 8: two-cycle latency, single valid cycle
        step(1'b1, 4'd8, 1'b0, 1'b1);
        chk("lat1_valid", int'(m_valid), 0);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("lat2_valid", int'(m_valid), 1);
        chk("g8_r", int'(m_r), 9);
        chk("g8_g", int'(m_g), 8);
        chk("g8_b", int'(m_b), 6);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("g8_one_cycle", int'(m_valid), 0);

        // gray 15: red saturates
        step(1'b1, 4'd15, 1'b0, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("g15_r", int'(m_r), 15);
        chk("g15_g", int'(m_g), 15);
        chk("g15_b", int'(m_b), 11);
`ifdef GRAY_TINT_SAT_FLAG_EN
        chk("g15_sat", int'(sat_flag), 1);
`endif
        step(1'b0, 4'd0, 1'b0, 1'b1);

        // bypass 5, then gray 0
        step(1'b1, 4'd5, 1'b1, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("byp_r", int'(m_r), 5);
        chk("byp_g", int'(m_g), 5);
        chk("byp_b", int'(m_b), 5);
        step(1'b1, 4'd0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("g0_r", int'(m_r), 0);
        chk("g0_g", int'(m_g), 0);
        chk("g0_b", int'(m_b), 0);
        drain();

        // randomized traffic with backpressure
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
                 logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 9) < 7));
        end
        drain();

        // in-order stream 0..15 with ready pattern 1,0,0,1 (bypass for unique values)
        g = 0;
        for (int cyc = 0; cyc < 100 && g < 16; cyc++) begin
            step(1'b1, 4'(g), 1'b1, logic'((cyc % 4 == 0) || (cyc % 4 == 3)));
            if (accepted) g++;
        end
        chk("stream_sent", g, 16);
        drain();

        // frame marking: 10 pixels from a fresh frame
        resetDut();
        for (int i = 0; i < 10; i++) step(1'b1, 4'(i), 1'b0, 1'b1);
        drain();
        chk("frame_outs", outCount, 10);
        chk("frame_nlast", lastPos.size(), 2);
        if (lastPos.size() == 2) begin
            chk("frame_last0", lastPos[0], 4);
            chk("frame_last1", lastPos[1], 8);
        end

        // reset during a stall with two pixels in flight
        step(1'b1, 4'd3, 1'b0, 1'b1);
        step(1'b1, 4'd7, 1'b0, 1'b0);
        step(1'b1, 4'd9, 1'b0, 1'b0);
        chk("stall_full_ready", int'(s_ready), 0);
        resetDut();
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 2), 1'b0, 1'b1);
        drain();
        chk("post_rst_outs", outCount, 4);
        chk("post_rst_nlast", lastPos.size(), 1);
        if (lastPos.size() == 1) chk("post_rst_last", lastPos[0], 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
